// File: rtl/mul_share_ctrl.sv
// mul_share_ctrl: shift-add multiply sequencer that shares one PW-bit adder
// between two requesters under round-robin arbitration.
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   req0_valid/req0_a/req0_b        requester 0 operands; req0_ready (comb) accepts
//   req1_valid/req1_a/req1_b        requester 1 operands; req1_ready (comb) accepts
//   res_valid/res_id/res_prod       registered product, held until res_ready
//   res_ready                       consumer takes the product
//   busy                            high while a multiply is in CALC or DONE
module mul_share_ctrl #(
    parameter int unsigned AW = 8,
    parameter int unsigned BW = 4,
    parameter int unsigned PW = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req0_valid,
    input  logic [AW-1:0] req0_a,
    input  logic [BW-1:0] req0_b,
    output logic          req0_ready,
    input  logic          req1_valid,
    input  logic [AW-1:0] req1_a,
    input  logic [BW-1:0] req1_b,
    output logic          req1_ready,
    output logic          res_valid,
    output logic          res_id,
    output logic [PW-1:0] res_prod,
    input  logic          res_ready,
    output logic          busy
);

    localparam int unsigned SW = (BW > 1) ? $clog2(BW) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t        r_state, w_state_nxt;
    logic [PW-1:0] r_acc, w_acc_nxt;
    logic [PW-1:0] r_sa, w_sa_nxt;
    logic [BW-1:0] r_b, w_b_nxt;
    logic [SW-1:0] r_step, w_step_nxt;
    logic          r_id, w_id_nxt;
    logic          r_last, w_last_nxt;
    logic          r_res_valid, w_res_valid_nxt;
    logic          r_res_id, w_res_id_nxt;
    logic [PW-1:0] r_res_prod, w_res_prod_nxt;

    logic          w_gnt0, w_gnt1;
    logic [PW-1:0] w_acc_add;

    // Round-robin: under contention the requester not granted last time wins.
    assign w_gnt0 = req0_valid && (!req1_valid || r_last);
    assign w_gnt1 = req1_valid && (!req0_valid || !r_last);

    assign req0_ready = (r_state == ST_IDLE) && w_gnt0;
    assign req1_ready = (r_state == ST_IDLE) && w_gnt1;

    // Multiplier bits are consumed LSB-first by shifting r_b right each step.
    assign w_acc_add = r_acc + (r_b[0] ? r_sa : '0);

    assign res_valid = r_res_valid;
    assign res_id    = r_res_id;
    assign res_prod  = r_res_prod;
    assign busy      = (r_state != ST_IDLE);

    // Next-state and datapath update.
    always_comb begin
        w_state_nxt     = r_state;
        w_acc_nxt       = r_acc;
        w_sa_nxt        = r_sa;
        w_b_nxt         = r_b;
        w_step_nxt      = r_step;
        w_id_nxt        = r_id;
        w_last_nxt      = r_last;
        w_res_valid_nxt = r_res_valid;
        w_res_id_nxt    = r_res_id;
        w_res_prod_nxt  = r_res_prod;

        case (r_state)
            ST_IDLE: begin
                if (w_gnt0 || w_gnt1) begin
                    w_sa_nxt    = w_gnt1 ? PW'(req1_a) : PW'(req0_a);
                    w_b_nxt     = w_gnt1 ? req1_b : req0_b;
                    w_acc_nxt   = '0;
                    w_id_nxt    = w_gnt1;
                    w_last_nxt  = w_gnt1;
                    w_step_nxt  = '0;
                    w_state_nxt = ST_CALC;
                end
            end
            ST_CALC: begin
                w_acc_nxt  = w_acc_add;
                w_sa_nxt   = r_sa << 1;
                w_b_nxt    = r_b >> 1;
                w_step_nxt = r_step + SW'(1);
                if (r_step == SW'(BW - 1)) begin
                    w_res_prod_nxt  = w_acc_add;
                    w_res_id_nxt    = r_id;
                    w_res_valid_nxt = 1'b1;
                    w_state_nxt     = ST_DONE;
                end
            end
            ST_DONE: begin
                if (r_res_valid && res_ready) begin
                    w_res_valid_nxt = 1'b0;
                    w_state_nxt     = ST_IDLE;
                end
            end
            default: begin
                w_res_valid_nxt = 1'b0;
                w_state_nxt     = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_acc       <= '0;
            r_sa        <= '0;
            r_b         <= '0;
            r_step      <= '0;
            r_id        <= 1'b0;
            r_last      <= 1'b1;
            r_res_valid <= 1'b0;
            r_res_id    <= 1'b0;
            r_res_prod  <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_acc       <= w_acc_nxt;
            r_sa        <= w_sa_nxt;
            r_b         <= w_b_nxt;
            r_step      <= w_step_nxt;
            r_id        <= w_id_nxt;
            r_last      <= w_last_nxt;
            r_res_valid <= w_res_valid_nxt;
            r_res_id    <= w_res_id_nxt;
            r_res_prod  <= w_res_prod_nxt;
        end
    end

endmodule

// File: tb/tb_mul_share_ctrl.sv
// Testbench for mul_share_ctrl: transaction-level model checked every cycle,
// directed scenarios with literal expectations, and an exhaustive operand sweep.
module tb_mul_share_ctrl;

    localparam int unsigned AW = 8;
    localparam int unsigned BW = 4;
    localparam int unsigned PW = 16;

    logic          clk;
    logic          rst_n;
    logic          req0_valid, req1_valid;
    logic [AW-1:0] req0_a, req1_a;
    logic [BW-1:0] req0_b, req1_b;
    logic          req0_ready, req1_ready;
    logic          res_valid, res_id, res_ready, busy;
    logic [PW-1:0] res_prod;

    mul_share_ctrl #(.AW(AW), .BW(BW), .PW(PW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_ready(req1_ready),
        .res_valid(res_valid), .res_id(res_id), .res_prod(res_prod),
        .res_ready(res_ready), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: one multiply in flight at most; result appears BW cycles after accept.
    logic        m_pend = 1'b0;
    int          m_cnt  = 0;
    logic        m_id   = 1'b0;
    logic        m_last = 1'b1;
    logic [31:0] m_prod = 0;
    logic [31:0] m_out_prod = 0;
    logic        m_out_id = 1'b0;
    int          n_acc = 0, n_res = 0, n_abort = 0;

    always @(negedge clk) begin
        logic exp_rv, g0, g1;
        if (!rst_n) begin
            chk("rst_res_valid", 32'(res_valid), 0);
            chk("rst_busy", 32'(busy), 0);
            chk("rst_res_id", 32'(res_id), 0);
            chk("rst_res_prod", 32'(res_prod), 0);
            if (m_pend) n_abort++;
            m_pend = 1'b0; m_cnt = 0; m_last = 1'b1;
            m_out_prod = 0; m_out_id = 1'b0;
        end else begin
            exp_rv = m_pend && (m_cnt == 0);
            g0 = !m_pend && req0_valid && (!req1_valid || m_last);
            g1 = !m_pend && req1_valid && (!req0_valid || !m_last);
            chk("req0_ready", 32'(req0_ready), 32'(g0));
            chk("req1_ready", 32'(req1_ready), 32'(g1));
            chk("busy", 32'(busy), 32'(m_pend));
            chk("res_valid", 32'(res_valid), 32'(exp_rv));
            chk("res_prod", 32'(res_prod), m_out_prod);
            chk("res_id", 32'(res_id), 32'(m_out_id));
            if (exp_rv) begin
                if (res_ready) begin
                    m_pend = 1'b0;
                    n_res++;
                end
            end else if (m_pend) begin
                m_cnt--;
                if (m_cnt == 0) begin
                    m_out_prod = m_prod;
                    m_out_id   = m_id;
                end
            end else if (g0 || g1) begin
                m_pend = 1'b1;
                m_cnt  = BW;
                m_id   = g1;
                m_last = g1;
                m_prod = g1 ? 32'(req1_a) * 32'(req1_b) : 32'(req0_a) * 32'(req0_b);
                n_acc++;
            end
        end
    end

    task automatic issue(input logic id, input logic [AW-1:0] a, input logic [BW-1:0] b);
        bit got = 1'b0;
        if (id) begin req1_valid = 1'b1; req1_a = a; req1_b = b; end
        else    begin req0_valid = 1'b1; req0_a = a; req0_b = b; end
        for (int i = 0; i < 400 && !got; i++) begin
            @(negedge clk);
            if ((id ? req1_ready : req0_ready) === 1'b1) got = 1'b1;
        end
        @(posedge clk); #1;
        if (id) req1_valid = 1'b0; else req0_valid = 1'b0;
        if (!got) chk("issue_timeout", 0, 1);
    endtask

    // Call right after the accepting edge; checks latency and the literal result.
    task automatic wait_res(input logic id, input logic [PW-1:0] prod, input string nm);
        int lat = 0;
        bit seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(posedge clk); #1;
            lat++;
            if (res_valid) seen = 1'b1;
        end
        chk({nm, "_latency"}, 32'(lat), 32'(BW));
        chk({nm, "_id"}, 32'(res_id), 32'(id));
        chk({nm, "_prod"}, 32'(res_prod), 32'(prod));
    endtask

    task automatic wait_idle();
        bit ok = 1'b0;
        for (int i = 0; i < 200 && !ok; i++) begin
            if (!busy && !res_valid) ok = 1'b1;
            else begin @(posedge clk); #1; end
        end
        chk("idle_timeout", 32'(ok), 1);
    endtask

    task automatic stream(input int id);
        for (int p = id; p < 4096; p += 2) begin
            issue(1'(id), AW'(p), BW'(p >> 8));
            if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int g_q[$];
        logic [PW-1:0] p_q[$];
        logic [PW-1:0] hold_p;
        logic          hold_id;
        int            res_before;
        bit            sweep_done;

        rst_n = 1'b0; res_ready = 1'b1;
        req0_valid = 1'b0; req0_a = '0; req0_b = '0;
        req1_valid = 1'b0; req1_a = '0; req1_b = '0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        // Basic product 0xFF * 0xF
        issue(1'b0, 8'hFF, 4'hF);
        wait_res(1'b0, 16'h0EF1, "t1");
        wait_idle();

        // Zero operands still take the full latency
        issue(1'b1, 8'h00, 4'hF);
        wait_res(1'b1, 16'h0000, "t2a");
        issue(1'b1, 8'h37, 4'h0);
        wait_res(1'b1, 16'h0000, "t2b");
        wait_idle();

        // Continuous contention: grants alternate
        req0_a = 8'h12; req0_b = 4'h3; req1_a = 8'h05; req1_b = 4'hA;
        req0_valid = 1'b1; req1_valid = 1'b1;
        for (int c = 0; c < 4 * (BW + 2) + 2; c++) begin
            @(negedge clk);
            if (req0_ready) g_q.push_back(0);
            if (req1_ready) g_q.push_back(1);
            if (res_valid && res_ready) p_q.push_back(res_prod);
            @(posedge clk); #1;
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        chk("t3_grant_count_ge4", 32'(g_q.size() >= 4), 1);
        chk("t3_result_count_ge2", 32'(p_q.size() >= 2), 1);
        if (g_q.size() >= 4) begin
            chk("t3_grant0", 32'(g_q[0]), 0);
            chk("t3_grant1", 32'(g_q[1]), 1);
            chk("t3_grant2", 32'(g_q[2]), 0);
            chk("t3_grant3", 32'(g_q[3]), 1);
        end
        if (p_q.size() >= 2) begin
            chk("t3_prod0", 32'(p_q[0]), 32'h36);
            chk("t3_prod1", 32'(p_q[1]), 32'h32);
        end
        wait_idle();

        // Backpressure: result held for 7 cycles, requests blocked
        res_ready = 1'b0;
        issue(1'b0, 8'h21, 4'h7);
        wait_res(1'b0, 16'h00E7, "t4");
        hold_p = res_prod; hold_id = res_id;
        req1_a = 8'h11; req1_b = 4'h2; req1_valid = 1'b1;
        for (int c = 0; c < 7; c++) begin
            @(posedge clk); #1;
            chk("t4_hold_valid", 32'(res_valid), 1);
            chk("t4_hold_prod", 32'(res_prod), 32'(hold_p));
            chk("t4_hold_id", 32'(res_id), 32'(hold_id));
            chk("t4_ready1_low", 32'(req1_ready), 0);
        end
        res_ready = 1'b1;
        @(posedge clk); #1;
        chk("t4_idle_after_release", 32'(busy), 0);
        chk("t4_ready1_after_release", 32'(req1_ready), 1);
        @(posedge clk); #1;
        req1_valid = 1'b0;
        chk("t4_accept_next", 32'(busy), 1);
        wait_res(1'b1, 16'h0022, "t4b");
        wait_idle();

        // Reset mid-CALC aborts the multiply at once
        issue(1'b0, 8'h55, 4'hF);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("t5_busy_async", 32'(busy), 0);
        chk("t5_valid_async", 32'(res_valid), 0);
        chk("t5_prod_async", 32'(res_prod), 0);
        chk("t5_id_async", 32'(res_id), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (BW + 3) begin @(posedge clk); #1; end
        req0_a = 8'h0A; req0_b = 4'h3; req1_a = 8'h09; req1_b = 4'h9;
        req0_valid = 1'b1; req1_valid = 1'b1;
        @(negedge clk);
        chk("t5_req0_wins", 32'(req0_ready), 1);
        chk("t5_req1_loses", 32'(req1_ready), 0);
        @(posedge clk); #1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        wait_res(1'b0, 16'h001E, "t5");
        wait_idle();

        // Exhaustive operand sweep with random backpressure
        res_before = n_res;
        sweep_done = 1'b0;
        fork
            begin
                fork
                    stream(0);
                    stream(1);
                join
                sweep_done = 1'b1;
            end
            begin
                while (!sweep_done) begin
                    @(posedge clk); #1;
                    res_ready = 1'($urandom_range(0, 1));
                end
            end
        join
        res_ready = 1'b1;
        wait_idle();
        chk("sweep_result_count", 32'(n_res - res_before), 4096);
        chk("no_lost_or_dup", 32'(n_res), 32'(n_acc - n_abort));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
